sha_msg_schedule: RTL

Streaming, parametrised SHA-2 message-schedule generator for the miner hash core. It accepts one padded message block, then emits the schedule words W[0..ROUNDS-1] one per cycle over a valid/ready stream to the compression round engine. A 16-word sliding window replaces a full 64-entry W array. The block supports SHA-256 and SHA-512 and accepts back-to-back blocks without bubbles.

---
 rtl/sha_pkg.sv | 80 ++++++++
 rtl/sha_msg_schedule_sigma.sv | 24 ++
 rtl/sha_msg_schedule.sv | 111 +++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-2 definitions: mode/state enums, per-mode constants and the small sigma/bswap helpers.
package sha_pkg;

  typedef enum logic {
    Sha256 = 1'b0,
    Sha512 = 1'b1
  } sha_mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } sched_state_e;

  localparam int unsigned Sha256WordW  = 32;
  localparam int unsigned Sha512WordW  = 64;
  localparam int unsigned Sha256Rounds = 64;
  localparam int unsigned Sha512Rounds = 80;

  // Rotate/shift amounts: {rotr_a, rotr_b, shr} for each small sigma.
  localparam int unsigned Sha256Sig0RotA = 7;
  localparam int unsigned Sha256Sig0RotB = 18;
  localparam int unsigned Sha256Sig0Shr  = 3;
  localparam int unsigned Sha256Sig1RotA = 17;
  localparam int unsigned Sha256Sig1RotB = 19;
  localparam int unsigned Sha256Sig1Shr  = 10;
  localparam int unsigned Sha512Sig0RotA = 1;
  localparam int unsigned Sha512Sig0RotB = 8;
  localparam int unsigned Sha512Sig0Shr  = 7;
  localparam int unsigned Sha512Sig1RotA = 19;
  localparam int unsigned Sha512Sig1RotB = 61;
  localparam int unsigned Sha512Sig1Shr  = 6;

  // Words live in a 64-bit container; in SHA-256 mode only the low 32 bits are meaningful.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n,
                                       input sha_mode_e mode);
    logic [31:0] x32;
    x32 = x[31:0];
    if (mode == Sha256) begin
      return {32'h0, (x32 >> n) | (x32 << (32 - n))};
    end
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] shr(input logic [63:0] x, input int unsigned n,
                                      input sha_mode_e mode);
    if (mode == Sha256) begin
      return {32'h0, x[31:0] >> n};
    end
    return x >> n;
  endfunction

  function automatic logic [63:0] sigma0(input logic [63:0] x, input sha_mode_e mode);
    if (mode == Sha256) begin
      return rotr(x, Sha256Sig0RotA, mode) ^ rotr(x, Sha256Sig0RotB, mode) ^
             shr(x, Sha256Sig0Shr, mode);
    end
    return rotr(x, Sha512Sig0RotA, mode) ^ rotr(x, Sha512Sig0RotB, mode) ^
           shr(x, Sha512Sig0Shr, mode);
  endfunction

  function automatic logic [63:0] sigma1(input logic [63:0] x, input sha_mode_e mode);
    if (mode == Sha256) begin
      return rotr(x, Sha256Sig1RotA, mode) ^ rotr(x, Sha256Sig1RotB, mode) ^
             shr(x, Sha256Sig1Shr, mode);
    end
    return rotr(x, Sha512Sig1RotA, mode) ^ rotr(x, Sha512Sig1RotB, mode) ^
           shr(x, Sha512Sig1Shr, mode);
  endfunction

  // Reverse the low nbytes bytes of x; bytes above nbytes come back as zero.
  function automatic logic [63:0] bswap(input logic [63:0] x, input int unsigned nbytes);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < nbytes; i++) begin
      y[8*i +: 8] = x[8*(nbytes-1-i) +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/sha_msg_schedule_sigma.sv
// Combinational small sigma (sigma0 when SEL=0, sigma1 when SEL=1) for the configured mode.
module sha_sigma
  import sha_pkg::*;
#(
  parameter int unsigned MODE   = 0,
  parameter int unsigned SEL    = 0,
  parameter int unsigned WORD_W = (MODE == 1) ? Sha512WordW : Sha256WordW
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  localparam sha_mode_e Mode = (MODE == 1) ? Sha512 : Sha256;

  // Widen into the package's 64-bit container, evaluate, narrow back.
  always_comb begin
    if (SEL == 0) begin
      y_o = WORD_W'(sigma0(64'(x_i), Mode));
    end else begin
      y_o = WORD_W'(sigma1(64'(x_i), Mode));
    end
  end

endmodule

// File: rtl/sha_msg_schedule.sv
// Streaming SHA-2 message schedule: loads a 16-word block, emits W[0..ROUNDS-1] over valid/ready
// using a 16-word sliding window.
module sha_msg_schedule
  import sha_pkg::*;
#(
  parameter int unsigned MODE      = 0,
  parameter int unsigned BYTE_SWAP = 1,
  localparam int unsigned WORD_W   = (MODE == 1) ? Sha512WordW : Sha256WordW,
  localparam int unsigned ROUNDS   = (MODE == 1) ? Sha512Rounds : Sha256Rounds,
  localparam int unsigned BLK_W    = 16 * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [6:0]        w_idx,
  output logic              w_last,
  output logic              busy
);

  sched_state_e      state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [WORD_W-1:0] blk_word [16];
  logic [WORD_W-1:0] s0, s1, w_new;
  logic              accept, load;

  sha_sigma #(
    .MODE   (MODE),
    .SEL    (0),
    .WORD_W (WORD_W)
  ) u_sigma0 (
    .x_i (win_q[1]),
    .y_o (s0)
  );

  sha_sigma #(
    .MODE   (MODE),
    .SEL    (1),
    .WORD_W (WORD_W)
  ) u_sigma1 (
    .x_i (win_q[14]),
    .y_o (s1)
  );

  // Outputs come straight from registered state; w_valid never looks at w_ready.
  assign w_valid   = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign w_last    = w_valid && (t_q == 7'(ROUNDS - 1));
  assign w_data    = win_q[0];
  assign w_idx     = t_q;
  assign accept    = w_valid && w_ready;
  assign blk_ready = (state_q == StIdle) || (accept && w_last);
  assign load      = blk_valid && blk_ready;
  // Past t = ROUNDS-16 this value is never emitted, so no need to gate it.
  assign w_new     = s1 + win_q[9] + s0 + win_q[0];

  // Split the incoming block into words, optionally byte-reversing each.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      blk_word[j] = blk_data[j*WORD_W +: WORD_W];
      if (BYTE_SWAP != 0) begin
        blk_word[j] = WORD_W'(bswap(64'(blk_word[j]), WORD_W / 8));
      end
    end
  end

  // Next-state: a load beats the shift when both happen on the last accept.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    if (load) begin
      win_d   = blk_word;
      t_d     = 7'd0;
      state_d = StRun;
    end else if (accept) begin
      for (int k = 0; k < 15; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[15] = w_new;
      if (w_last) begin
        state_d = StIdle;
        t_d     = 7'd0;
      end else begin
        t_d = t_q + 7'd1;
      end
    end
  end

  // State, round counter and window registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= 7'd0;
      for (int j = 0; j < 16; j++) begin
        win_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

endmodule
